// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_mem_pkg : sizes, FSM and RW encodings shared with the processor
// Rev 1.0
// ------------------------------------------------------------------
package instr_mem_pkg;

   localparam int DEPTH = 16;
   localparam int WIDTH = 32;

   typedef logic [0:0] state_t;

   localparam state_t ST_LOAD  = 1'b0;
   localparam state_t ST_READY = 1'b1;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/instr_ram.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_ram : single-port storage, synchronous write, registered read
// Rev 1.0
// ------------------------------------------------------------------
module instr_ram #(
   parameter int DEPTH = instr_mem_pkg::DEPTH,
   parameter int WIDTH = instr_mem_pkg::WIDTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic                     re,
   input  logic                     clr,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // No reset on the array: contents survive reset by design.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Output register holds when neither read nor clear is requested.
   always_ff @(posedge clk) begin
      if (clr) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_mem.sv
`default_nettype none
// ------------------------------------------------------------------
// instr_mem : instruction memory filled by a loader, then read/written by the CPU
// Rev 1.0
// ------------------------------------------------------------------
module instr_mem #(
   parameter int DEPTH = instr_mem_pkg::DEPTH,
   parameter int WIDTH = instr_mem_pkg::WIDTH
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     Ld_Valid,
   input  logic [WIDTH-1:0]         Ld_Data,
   input  logic                     Ld_Last,
   output logic                     Ld_Ready,
   input  logic                     Reload,
   input  logic [$clog2(DEPTH)-1:0] Addr,
   input  logic [WIDTH-1:0]         WData,
   input  logic                     RW,
   input  logic                     En,
   output logic [WIDTH-1:0]         Data,
   output logic                     Valid,
   output logic                     Prog_Ready,
   output logic [$clog2(DEPTH):0]   Len
);

   import instr_mem_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL     = LW'(DEPTH);
   localparam logic [LW-1:0] LAST_IDX = LW'(DEPTH - 1);
   localparam logic [LW-1:0] ONE      = LW'(1);

   state_t          state;
   state_t          state_nx;
   logic [LW-1:0]   len_nx;
   logic            in_range;
   logic            ld_xfer;
   logic            proc_rd;
   logic            proc_wr;
   logic            ram_we;
   logic            ram_re;
   logic            ram_clr;
   logic [AW-1:0]   ram_addr;
   logic [WIDTH-1:0] ram_wdata;

   assign in_range = ({1'b0, Addr} < Len);

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state <= ST_LOAD;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (Reload) begin
         state_nx = ST_LOAD;
      end else if ((state == ST_LOAD) && ld_xfer && (Ld_Last || (Len == LAST_IDX))) begin
         state_nx = ST_READY;
      end
   end

   // Reset and Reload both suppress every access issued on that edge.
   always_comb begin
      ld_xfer = 1'b0;
      proc_rd = 1'b0;
      proc_wr = 1'b0;
      if (Rst && !Reload) begin
         if (state == ST_LOAD) begin
            ld_xfer = Ld_Valid && Ld_Ready && (Len < FULL);
         end else begin
            proc_rd = En && (RW == RW_READ);
            proc_wr = En && (RW == RW_WRITE) && in_range;
         end
      end

      ram_we    = ld_xfer || proc_wr;
      ram_re    = proc_rd && in_range;
      ram_clr   = !Rst || (proc_rd && !in_range);
      ram_addr  = (state == ST_LOAD) ? Len[AW-1:0] : Addr;
      ram_wdata = (state == ST_LOAD) ? Ld_Data : WData;

      len_nx = Len;
      if (Reload) begin
         len_nx = '0;
      end else if (ld_xfer) begin
         len_nx = Len + ONE;
      end
   end

   // Status flags are decoded from the next state so they line up with it.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         Len        <= '0;
         Valid      <= 1'b0;
         Prog_Ready <= 1'b0;
         Ld_Ready   <= 1'b1;
      end else begin
         Len        <= len_nx;
         Valid      <= proc_rd;
         Prog_Ready <= (state_nx == ST_READY);
         Ld_Ready   <= (state_nx == ST_LOAD) && (len_nx < FULL);
      end
   end

   instr_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_ram (
      .clk   (Clk),
      .we    (ram_we),
      .re    (ram_re),
      .clr   (ram_clr),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (Data)
   );

endmodule
`default_nettype wire

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 Parameter DEPTH, 16, number of 32-bit instruction words; address width is 4 bits.
REQ-002 Parameter WIDTH, 32, instruction word width.
REQ-003 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-004 Rst  input  1  reset, synchronous, active-low.
REQ-005 Ld_Valid  input  1  loader word valid.
REQ-006 Ld_Data  input  32  loader instruction word.
REQ-007 Ld_Last  input  1  marks final word of program, qualified by Ld_Valid.
REQ-008 Ld_Ready  output  1  loader may transfer; a transfer occurs when Ld_Valid and Ld_Ready are both high at posedge.
REQ-009 Reload  input  1  pulse: discard program, return to LOAD.
REQ-010 Addr  input  4  processor word address.
REQ-011 WData  input  32  processor write data.
REQ-012 RW  input  1  0 = read, 1 = write; qualified by En.
REQ-013 En  input  1  processor access strobe.
REQ-014 Data  output  32  registered read data.
REQ-015 Valid  output  1  one-cycle pulse: Data holds the result of the previous cycle's read.
REQ-016 Prog_Ready  output  1  high in READY; gates processor start.
REQ-017 Len  output  5  number of loaded words, 0..16.

Function
REQ-018 The FSM SHALL have exactly two states: LOAD and READY.
REQ-019 In LOAD, Ld_Ready SHALL be high while Len<16; each transfer writes Ld_Data to mem[Len] and increments Len by 1.
REQ-020 A transfer with Ld_Last=1, or the transfer that makes Len reach 16, SHALL move LOAD->READY on that edge.
REQ-021 Ld_Ready SHALL be low in READY; Ld_Valid in READY SHALL be ignored.
REQ-022 In LOAD, processor accesses SHALL be ignored: Valid stays 0 and Data holds its value.
REQ-023 In READY, En=1 and RW=0 SHALL load Data<=mem[Addr] when Addr<Len, else Data<=0, and SHALL assert Valid on the next cycle; read latency is exactly 1 cycle.
REQ-024 In READY, En=1 and RW=1 with Addr<Len SHALL write mem[Addr]<=WData with Valid=0; with Addr>=Len the write SHALL be dropped.
REQ-025 Back-to-back reads on consecutive cycles SHALL each produce one Valid pulse, in order.
REQ-026 Reload=1 in any state SHALL force LOAD and Len<=0 on that edge; Reload SHALL take priority over a simultaneous En access or loader transfer, both of which are discarded.
REQ-027 Reload in LOAD with Len>0 SHALL restart loading at address 0.
REQ-028 Prog_Ready SHALL be a registered decode of state == READY.

Reset
REQ-029 On a posedge with Rst=0: state<=LOAD, Len<=0, Data<=0, Valid<=0, Prog_Ready<=0, Ld_Ready<=1.
REQ-030 Memory contents SHALL NOT be cleared by reset; reads beyond Len return 0 regardless of contents.
REQ-031 Reset asserted mid-load or mid-read SHALL abandon the operation with no partial write and no Valid pulse.

Structure
REQ-032 DEPTH, WIDTH, the state encoding (LOAD=0, READY=1) and the processor RW encoding SHALL live in a shared package used by both this block and the processor.
REQ-033 The storage array SHALL be one sub-module, instr_ram (single port, synchronous write, registered read), instantiated once.

Verification
REQ-034 Load 9 words 0x20010005..0x2009000D, Ld_Last on the 9th -> Len=9, Prog_Ready=1 on the following cycle, Ld_Ready=0.
REQ-035 READY, read Addr=3 -> next cycle Data=0x20040008, Valid=1 for exactly one cycle; read Addr=12 -> Data=0.
REQ-036 Load 16 words without Ld_Last -> READY after the 16th transfer; a 17th Ld_Valid is not accepted and Len stays 16.
REQ-037 READY, Reload and En read on the same cycle -> state LOAD, Len=0, no Valid; a new 2-word load then reads back the new words.
REQ-038 Rst=0 after 4 loaded words -> Len=0, Prog_Ready=0, Data=0; write RW=1 to Addr=2 during LOAD -> ignored.
